// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-port signals shared by the arbiter and its environment
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_rw;
  logic [1:0]  d_store_sel;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic        d_err;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_rw;
  logic [31:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;
  modport master (
    input  if_req, if_addr, d_req, d_rw, d_store_sel, d_addr, d_wdata, m_ack, m_rdata,
    output if_ack, if_rdata, d_ack, d_err, d_rdata, m_req, m_rw, m_addr, m_be, m_wdata
  );
  modport slave (
    output if_req, if_addr, d_req, d_rw, d_store_sel, d_addr, d_wdata, m_ack, m_rdata,
    input  if_ack, if_rdata, d_ack, d_err, d_rdata, m_req, m_rw, m_addr, m_be, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters with bounded fetch starvation
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W = 3
) (
  input logic clock,
  input logic reset,
  mem_port_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, ERR} state_t;
  state_t state_q, state_d;
  logic m_req_q, m_req_d, m_rw_q, m_rw_d;
  logic if_ack_q, if_ack_d, d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic [3:0] m_be_q, m_be_d, lane_be;
  logic [31:0] lane_wdata;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [1:0] a, sel;
  logic misal, starved, if_ok, d_ok, f_win, d_win;
  always_comb begin
    a = bus.d_addr[1:0];
    sel = bus.d_store_sel == 2'b11 ? 2'b00 : bus.d_store_sel;
    lane_be = sel == 2'b01 ? 4'b0011 << a : sel == 2'b10 ? 4'b0001 << a : 4'b1111;
    lane_wdata = sel == 2'b01 ? {2{bus.d_wdata[15:0]}} : sel == 2'b10 ? {4{bus.d_wdata[7:0]}} : bus.d_wdata;
    misal = bus.d_rw & (((sel == 2'b01) & a[0]) | ((sel == 2'b00) & (a != 2'b00)));
    starved = starve_q == CNT_W'(STARVE_MAX);
    if_ok = bus.if_req & ~if_ack_q;
    d_ok = bus.d_req & ~d_ack_q;
    f_win = if_ok & (~bus.d_req | starved);
    d_win = d_ok & ~f_win;
    state_d = state_q;
    m_req_d = m_req_q;
    m_rw_d = m_rw_q;
    m_addr_d = m_addr_q;
    m_be_d = m_be_q;
    m_wdata_d = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d = d_rdata_q;
    starve_d = starve_q;
    if_ack_d = 1'b0;
    d_ack_d = 1'b0;
    d_err_d = 1'b0;
    if (state_q == IDLE && f_win) begin
      state_d = BUSY_I;
      m_req_d = 1'b1;
      m_rw_d = 1'b0;
      m_addr_d = {bus.if_addr[31:2], 2'b00};
      m_be_d = 4'b1111;
      starve_d = '0;
    end else if (state_q == IDLE && d_win && misal) begin
      state_d = ERR;
    end else if (state_q == IDLE && d_win) begin
      state_d = BUSY_D;
      m_req_d = 1'b1;
      m_rw_d = bus.d_rw;
      m_addr_d = {bus.d_addr[31:2], 2'b00};
      m_be_d = bus.d_rw ? lane_be : 4'b1111;
      m_wdata_d = lane_wdata;
      starve_d = !bus.if_req ? '0 : starved ? starve_q : starve_q + 1'b1;
    end else if (state_q == BUSY_I && bus.m_ack) begin
      state_d = IDLE;
      m_req_d = 1'b0;
      if_ack_d = 1'b1;
      if_rdata_d = bus.m_rdata;
    end else if (state_q == BUSY_D && bus.m_ack) begin
      state_d = IDLE;
      m_req_d = 1'b0;
      d_ack_d = 1'b1;
      d_rdata_d = bus.m_rdata;
    end else if (state_q == ERR) begin
      state_d = IDLE;
      d_ack_d = 1'b1;
      d_err_d = 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      m_req_q <= 1'b0;
      m_rw_q <= 1'b0;
      m_addr_q <= '0;
      m_be_q <= '0;
      m_wdata_q <= '0;
      if_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      d_err_q <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q <= '0;
      starve_q <= '0;
    end else begin
      state_q <= state_d;
      m_req_q <= m_req_d;
      m_rw_q <= m_rw_d;
      m_addr_q <= m_addr_d;
      m_be_q <= m_be_d;
      m_wdata_q <= m_wdata_d;
      if_ack_q <= if_ack_d;
      d_ack_q <= d_ack_d;
      d_err_q <= d_err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q <= d_rdata_d;
      starve_q <= starve_d;
    end
  end
  assign bus.m_req = m_req_q;
  assign bus.m_rw = m_rw_q;
  assign bus.m_addr = m_addr_q;
  assign bus.m_be = m_be_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.if_ack = if_ack_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_ack = d_ack_q;
  assign bus.d_err = d_err_q;
  assign bus.d_rdata = d_rdata_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port between the instruction-fetch requester and the memory-stage data requester. The data requester is driven by the memory-stage decode outputs (rw, store_sel).
- Sequences one outstanding transaction at a time.
- Generates byte enables and lane-shifted write data for SW/SH/SB.
- Rejects misaligned stores.
- Bounds fetch starvation.

Parameters:
- STARVE_MAX, 4: maximum consecutive data grants while if_req is pending before fetch is forced to win.
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W > STARVE_MAX.

Ports:
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  32  fetch word address; bits [1:0] ignored
- if_ack  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched word
- d_req  in  1  data request; held until d_ack
- d_rw  in  1  0 = MEM_READ, 1 = MEM_WRITE
- d_store_sel  in  2  00 = STORE_W, 01 = STORE_H, 10 = STORE_B, 11 = treated as STORE_W
- d_addr  in  32  byte address
- d_wdata  in  32  store data, right-aligned
- d_ack  out  1  one-cycle completion pulse
- d_err  out  1  valid with d_ack; 1 = misaligned store, not issued
- d_rdata  out  32  raw loaded word (extension is done downstream)
- m_req  out  1  memory request; held until m_ack
- m_rw  out  1  0 = read, 1 = write
- m_addr  out  32  word-aligned address, bits [1:0] = 00
- m_be  out  4  byte enables; 1111 for reads
- m_wdata  out  32  lane-shifted write data
- m_ack  in  1  memory completion, any latency ≥ 1 cycle after m_req
- m_rdata  in  32  valid when m_ack

Behaviour:
- Reset values: state = IDLE, m_req = 0, m_rw = 0, m_addr = 0, m_be = 0, m_wdata = 0, if_ack = 0, d_ack = 0, d_err = 0, if_rdata = 0, d_rdata = 0, starve_cnt = 0.
- States: IDLE, BUSY_I, BUSY_D, ERR.
- IDLE arbitration, evaluated each cycle:
  - Fetch wins if only if_req is set, or if both are set and starve_cnt == STARVE_MAX.
  - Otherwise data wins if d_req is set.
  - Ties go to data, because the older instruction must complete first.
- Grant to fetch: next cycle m_req = 1, m_rw = 0, m_be = 1111, m_addr = {if_addr[31:2], 00}; state -> BUSY_I; starve_cnt -> 0.
- Grant to data, aligned:
  - m_req = 1, m_rw = d_rw, m_addr = {d_addr[31:2], 00}; state -> BUSY_D.
  - starve_cnt increments (saturating at STARVE_MAX) if if_req is high, else clears to 0.
- Grant to data, misaligned store: state -> ERR; m_req stays 0.
  - Misaligned means d_rw = 1 and either STORE_H with d_addr[0] = 1, or STORE_W with d_addr[1:0] != 00.
  - Loads are never checked.
- Byte lanes for writes (a = d_addr[1:0]):
  - W: be = 1111, wdata = d_wdata.
  - H: be = 0011 << a, wdata = {2{d_wdata[15:0]}}.
  - B: be = 0001 << a, wdata = {4{d_wdata[7:0]}}.
- Outputs in BUSY: m_req, m_rw, m_addr, m_be and m_wdata are registered and held stable until m_ack.
- BUSY_x on m_ack, same edge:
  - m_req -> 0.
  - Corresponding *_ack -> 1 for exactly one cycle; *_rdata <= m_rdata (d_rdata also captured on writes, value don't-care).
  - State -> IDLE.
- ERR: d_ack = 1 and d_err = 1 for one cycle; state -> IDLE.
- Back-to-back: the requester drops or changes its request in the cycle after ack. IDLE therefore never re-grants a request whose ack is being pulsed: a requester whose ack is high this cycle is masked from arbitration.
- Minimum transaction: 1 cycle IDLE→BUSY, at least 1 BUSY cycle, 1 cycle ack. No pipelining; at most one outstanding request.
- m_ack while in IDLE or ERR: ignored.
- Reset asserted mid-transaction: state is forced to IDLE and all outputs take their reset values on that edge. A memory ack that arrives afterwards is ignored. Requesters must reissue.

Test Plan:
- Fetch only: if_req = 1, if_addr = 0x103, m_ack after 2 cycles with m_rdata = 0xDEADBEEF → m_addr = 0x100, m_be = 1111, m_rw = 0; if_ack is a one-cycle pulse with if_rdata = 0xDEADBEEF.
- SB store: d_req = 1, d_rw = 1, d_store_sel = 10, d_addr = 0x22, d_wdata = 0x000000AB → m_addr = 0x20, m_be = 0100, m_wdata = 0xABABABAB; d_ack = 1, d_err = 0.
- SH misaligned: d_store_sel = 01, d_addr = 0x41, d_rw = 1 → m_req never asserted; d_ack = 1 with d_err = 1 two cycles after d_req.
- Contention: both requests held continuously, STARVE_MAX = 4 → grant order D, D, D, D, I, D, …; starve_cnt returns to 0 after the fetch grant.
- Simultaneous first request → data granted first; fetch granted in the IDLE cycle after d_ack.
- Reset asserted while BUSY_D awaiting m_ack → next cycle m_req = 0, state IDLE; a subsequent m_ack produces no d_ack.
